// File: rtl/updn_counter_ext.sv
// updn_counter_ext: parametrised loadable up/down counter with a programmable
// inclusive upper bound, per-cycle step, wrap or saturate behaviour, sticky
// overflow/underflow flags and a combinational terminal-count output.
// With WIDTH=3, STEP_W=1, max_val=7, step=1, SATURATE=0 it behaves like the
// original 3-bit up/down counter.
module updn_counter_ext #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 2,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld_cnt,
    input  logic              updn_cnt,
    input  logic              count_enb,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              ovf_flag,
    output logic              unf_flag
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             setOvf, setUnf;

    // All count arithmetic is one bit wider than the counter so that
    // max_val+1 and count+step never overflow before being compared.
    logic [WIDTH:0]   cntExt, maxExt, stepExt, rangeExt, sumExt;
    logic             overRange;
    logic [WIDTH-1:0] diffVal, wrapUpVal, wrapDnVal;

    assign cntExt    = {1'b0, count_q};
    assign maxExt    = {1'b0, max_val};
    assign stepExt   = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign rangeExt  = maxExt + 1'b1;
    assign sumExt    = cntExt + stepExt;
    // A step larger than the whole range cannot wrap meaningfully, so it
    // always pins the result to the bound being crossed.
    assign overRange = stepExt > rangeExt;
    assign diffVal   = WIDTH'(cntExt - stepExt);
    assign wrapUpVal = WIDTH'(sumExt - rangeExt);
    assign wrapDnVal = WIDTH'(cntExt + rangeExt - stepExt);

    // Next-state selection: load beats range correction, which beats counting.
    always_comb begin
        count_d = count_q;
        setOvf  = 1'b0;
        setUnf  = 1'b0;
        if (!ld_cnt) begin
            count_d = (data_in > max_val) ? max_val : data_in;
        end else if (count_q > max_val) begin
            count_d = max_val;
        end else if (count_enb) begin
            if (updn_cnt) begin
                if (sumExt <= maxExt) begin
                    count_d = sumExt[WIDTH-1:0];
                end else begin
                    setOvf  = 1'b1;
                    count_d = ((SATURATE != 0) || overRange) ? max_val : wrapUpVal;
                end
            end else begin
                if (stepExt <= cntExt) begin
                    count_d = diffVal;
                end else begin
                    setUnf  = 1'b1;
                    count_d = ((SATURATE != 0) || overRange) ? '0 : wrapDnVal;
                end
            end
        end
        // A crossing in the same cycle as a clear keeps the flag set.
        ovf_d = (ovf_q & ~clr_flags) | setOvf;
        unf_d = (unf_q & ~clr_flags) | setUnf;
    end

    // Count and sticky flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_out = count_q;
    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;
    assign tc       = updn_cnt ? (count_q == max_val) : (count_q == '0);

endmodule
